lc3_branch_resolve: RTL and testbench
=====================================

Name: lc3_branch_resolve

Overview:
- Downstream consumer of the NZP condition-code register in the LC-3 datapath.
- On request, it latches the current instruction, PC and N/Z/P flags, and evaluates the BR condition (BEN).
- It computes the PC-relative target and issues a one-cycle PC-load pulse to the PC mux when the branch is taken.
- A running count of taken branches is kept for debug and performance visibility.

Parameters:
- OPC_BR, 4'b0000, opcode value recognised as BR.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on rising clk; 0 = reset.
- start  in  1  request to resolve the instruction on IR; honoured only in IDLE.
- IR  in  16  instruction register contents.
- PC  in  16  already-incremented PC (PC+1 of the BR instruction).
- N  in  1  condition code from the NZP register.
- Z  in  1  condition code from the NZP register.
- P  in  1  condition code from the NZP register.
- busy  out  1  high while in EVAL or RESP.
- done  out  1  one-cycle pulse: result valid.
- BEN  out  1  registered branch-enable result.
- pc_load  out  1  one-cycle pulse, coincident with done, only when BEN=1.
- target  out  16  branch target address.
- taken_count  out  CNT_W  number of taken branches since reset.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - busy, done, BEN, pc_load, target, taken_count all clear to 0.
  - Internal latches clear to 0.
  - Reset overrides everything, including mid-operation; any pending request is dropped and no done is produced.
- State machine: IDLE -> EVAL -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If start==1, latch IR, PC and {N,Z,P} into internal snapshot registers, then go to EVAL.
  - Otherwise stay in IDLE.
  - busy=0, done=0, pc_load=0.
- EVAL (1 cycle), using only the snapshot:
  - br = (IR[15:12]==OPC_BR).
  - If IR[11:9]==3'b111: cond=1 unconditionally, even when the snapshot NZP is 000 (power-up).
  - Otherwise: cond = (IR[11]&N) | (IR[10]&Z) | (IR[9]&P).
  - BEN_next = br & cond. IR[11:9]==000 is therefore never taken.
  - target_next = PC + sign_extend(IR[8:0]), 16-bit modulo 2^16 (wraps, no overflow flag). Computed even when not taken or not BR.
  - Go to RESP. busy=1.
- RESP (1 cycle):
  - done=1, BEN and target valid, pc_load=BEN.
  - If BEN, taken_count increments by 1, wrapping from all-ones to 0.
  - busy=1. Go to IDLE.
- Latency: start sampled at edge t -> done/pc_load high during the cycle following edge t+2. Three cycles from request to the next possible acceptance.
- start while busy is ignored: not queued, no error.
- Inputs IR, PC, N, Z, P may change freely after the accepting edge; the result depends only on the snapshot.
- BEN and target hold their last values after done until the next EVAL completes. done and pc_load are strictly single-cycle.
- start held high continuously gives back-to-back resolves every 3 cycles.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> all outputs 0, busy=0; no done for 10 cycles with start=0.
- Taken backward branch: PC=0x3001, IR=0x05FE (BRz -2), Z=1 -> done with BEN=1, pc_load=1, target=0x2FFF exactly 2 cycles after the accepting edge; taken_count=1.
- Not taken: PC=0x3001, IR=0x0A05 (BRnp +5), Z=1 -> done with BEN=0, pc_load=0, target=0x3006; taken_count unchanged. Then IR=0x0005 (nzp=000) with N=1 -> BEN=0.
- Unconditional and wrap-around: after reset (snapshot NZP=000), PC=0xFFFF, IR=0x0E01 (BRnzp +1) -> BEN=1, target=0x0000. Non-BR IR=0x1E01 with N=1 -> BEN=0, pc_load=0.
- Snapshot and busy rules: start with IR=0x05FE, Z=1; next cycle change Z=0, N=1 and hold start=1 -> first result BEN=1 (snapshot); second request is accepted only 3 cycles after the first.
- Reset mid-operation: start accepted, reset=0 during EVAL -> no done/pc_load pulse, taken_count=0, busy=0 next cycle. Counter wrap: preload via 0xFFFF taken branches (CNT_W reduced to 4: 15 branches) -> next taken gives taken_count=0.

Source files
------------

// File: rtl/lc3_branch_resolve_if.sv
// Request/result bundle between the LC-3 control path and the branch resolver.
// The requester drives the instruction, the incremented PC and the NZP flags.
// The resolver returns the branch decision, the target address and a debug counter.
interface lc3_branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [15:0]      IR;
  logic [15:0]      PC;
  logic             N;
  logic             Z;
  logic             P;
  logic             busy;
  logic             done;
  logic             BEN;
  logic             pc_load;
  logic [15:0]      target;
  logic [CNT_W-1:0] taken_count;

  // Requester side: issues resolve requests and consumes results.
  modport master (
    output start, IR, PC, N, Z, P,
    input  busy, done, BEN, pc_load, target, taken_count
  );

  // Resolver side.
  modport slave (
    input  start, IR, PC, N, Z, P,
    output busy, done, BEN, pc_load, target, taken_count
  );
endinterface

// File: rtl/lc3_branch_resolve.sv
// LC-3 branch resolver.
// Snapshots IR/PC/NZP on request, evaluates BEN one cycle later, then reports
// the result with a single-cycle done pulse (plus pc_load when taken).
// A wrapping counter tracks how many branches were taken since reset.
module lc3_branch_resolve #(
  parameter logic [3:0] OPC_BR = 4'b0000,
  parameter int         CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  lc3_branch_resolve_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Snapshot taken on the accepting edge; evaluation never looks at live inputs.
  logic [15:0]      ir_q, ir_d;
  logic [15:0]      pc_q, pc_d;
  logic [2:0]       nzp_q, nzp_d;

  // Registered outputs.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ben_q, ben_d;
  logic             pc_load_q, pc_load_d;
  logic [15:0]      target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Condition test: nzp=111 is unconditional so it is taken even with the
  // power-up flags 000; nzp=000 can never match and is never taken.
  function automatic logic branch_cond(input logic [2:0] ir_nzp,
                                       input logic [2:0] flags);
    if (ir_nzp == 3'b111) begin
      return 1'b1;
    end
    return |(ir_nzp & flags);
  endfunction

  // PC-relative target: sign-extended 9-bit offset, wraps modulo 2^16.
  function automatic logic [15:0] pc_rel_target(input logic [15:0] pc,
                                                input logic [8:0]  off9);
    logic signed [15:0] off_sx;
    off_sx = signed'({{7{off9[8]}}, off9});
    return pc + $unsigned(off_sx);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a fixed three-cycle walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_EVAL;
      S_EVAL:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; done and pc_load fire on the edge that leaves RESP.
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    nzp_d     = nzp_q;
    ben_d     = ben_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_RESP);
    pc_load_d = (state_q == S_RESP) && ben_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ir_d  = bus.IR;
          pc_d  = bus.PC;
          nzp_d = {bus.N, bus.Z, bus.P};
        end
      end
      S_EVAL: begin
        ben_d    = (ir_q[15:12] == OPC_BR) && branch_cond(ir_q[11:9], nzp_q);
        target_d = pc_rel_target(pc_q, ir_q[8:0]);
      end
      S_RESP: begin
        if (ben_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ben_d = ben_q;
      end
    endcase
  end

  // Register bank: snapshot, result and counter, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q      <= '0;
      pc_q      <= '0;
      nzp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ben_q     <= 1'b0;
      pc_load_q <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      nzp_q     <= nzp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ben_q     <= ben_d;
      pc_load_q <= pc_load_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.BEN         = ben_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.target      = target_q;
  assign bus.taken_count = cnt_q;

endmodule

// File: tb/tb_lc3_branch_resolve.sv
// Scoreboard bench for lc3_branch_resolve with a narrow counter so wrap is reachable.
module tb_lc3_branch_resolve;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  lc3_branch_resolve_if #(.CNT_W(CNT_W)) bus ();

  lc3_branch_resolve #(.OPC_BR(4'b0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ben;
    logic [15:0] target;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   next_acc = 0;
  int   last_acc = -10;
  int   mcnt     = 0;

  // Reference: BR taken iff opcode 0 and (nzp==7 or any selected flag set).
  function automatic logic model_ben(input logic [15:0] ir, input logic n,
                                     input logic z, input logic p);
    int opc;
    int code;
    opc  = int'(ir) / 4096;
    code = (int'(ir) / 512) % 8;
    if (opc != 0) return 1'b0;
    if (code == 7) return 1'b1;
    return ((code >= 4) && n) || (((code / 2) % 2 == 1) && z) || ((code % 2 == 1) && p);
  endfunction

  function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [15:0] ir);
    int off;
    off = int'(ir) % 512;
    if (off >= 256) off = off - 512;
    return 16'((int'(pc) + off + 65536) % 65536);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and record what the accepting edge (if any) must produce.
  task automatic step(input logic rst_v, input logic st, input logic [15:0] ir,
                      input logic [15:0] pc, input logic n, input logic z, input logic p);
    int   e;
    exp_t x;
    @(negedge clk);
    #2;
    reset     = rst_v;
    bus.start = st;
    bus.IR    = ir;
    bus.PC    = pc;
    bus.N     = n;
    bus.Z     = z;
    bus.P     = p;
    e = cyc + 1;
    if (!rst_v) begin
      next_acc = e + 1;
      last_acc = -10;
    end else if (st && e >= next_acc) begin
      x.ben    = model_ben(ir, n, z, p);
      x.target = model_target(pc, ir);
      x.due    = e + 2;
      sbq.push_back(x);
      last_acc = e;
      next_acc = e + 3;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  // Monitor: compares every presented result against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!reset) begin
      chk("reset_outputs",
          {8'h0, bus.busy, bus.done, bus.BEN, bus.pc_load, bus.target, bus.taken_count}, 32'h0);
      sbq.delete();
      mcnt = 0;
    end else begin
      chk("busy", 32'(bus.busy), 32'((cyc == last_acc) || (cyc == last_acc + 1)));
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'(bus.done), 32'h0);
        end else begin
          x = sbq.pop_front();
          mcnt = (mcnt + int'(x.ben)) % (1 << CNT_W);
          chk("done_cycle", 32'(cyc), 32'(x.due));
          chk("ben", 32'(bus.BEN), 32'(x.ben));
          chk("pc_load", 32'(bus.pc_load), 32'(x.ben));
          chk("target", 32'(bus.target), 32'(x.target));
          chk("taken_count", 32'(bus.taken_count), 32'(mcnt));
        end
      end else begin
        chk("pc_load_idle", 32'(bus.pc_load), 32'h0);
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          chk("missing_done", 32'h0, 32'h1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] ir;
    bus.start = 1'b0;
    bus.IR    = '0;
    bus.PC    = '0;
    bus.N     = 1'b0;
    bus.Z     = 1'b0;
    bus.P     = 1'b0;

    // Reset held for two cycles, then quiet idle.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Taken backward branch, not-taken cases.
    step(1'b1, 1'b1, 16'h05FE, 16'h3001, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 16'h0A05, 16'h3001, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 16'h0005, 16'h3001, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Unconditional with power-up flags and PC wrap; non-BR opcode.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0E01, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 16'h1E01, 16'h3001, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Snapshot isolation with start held high across the busy window.
    step(1'b1, 1'b1, 16'h05FE, 16'h3001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h05FE, 16'h3001, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset during EVAL drops the request.
    step(1'b1, 1'b1, 16'h0E01, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0E01, 16'h1234, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Counter wrap: sixteen back-to-back taken branches.
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 16'h0E01, 16'(i), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic, mostly BR opcodes, occasional reset.
    for (int i = 0; i < 500; i++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 9) < 8) ir[15:12] = 4'b0000;
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 9) < 7), ir, 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(6);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
